// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_e   : receiver frame states
//   PARITY_*     : parity mode codes for the PARITY parameter
//   maj3         : 2-of-3 vote used to decide each sampled bit
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Emits a one-cycle tick every round(CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE))
// clock cycles. A restart pulse re-phases the divider so the first tick
// lands one full tick period after the restart cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : re-phase the divider (start edge seen)
//   tick       : one-cycle sample strobe
module uart_baud_tick #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV      = BAUD_RATE * OVERSAMPLE;
  localparam int TICK_RAW = (CLOCK_FREQ + DIV / 2) / DIV;
  localparam int TICK     = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int CW       = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with a one-entry holding register.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// one stop bit. Bits are decided by a 2-of-3 vote of the oversample ticks
// around the bit centre.
// Handshake: data_out_valid means the holding register is full; it stays
// high, with data_out/frame_err/parity_err stable, until a cycle where
// data_out_valid && data_out_ready, which empties it.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   serial_in             : RX line (asynchronous, idle high)
//   data_out              : received payload
//   data_out_valid/ready  : holding register handshake
//   frame_err, parity_err : error flags of the held byte
//   overrun               : sticky, a completed frame was dropped
//   clear_overrun         : single-cycle pulse clearing overrun
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  input  logic                 clear_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  // Tick index OVERSAMPLE/2-1 is the bit centre c; the vote uses c-1, c, c+1
  // and is resolved on tick c+1.
  localparam logic [TW-1:0] T_CENTRE = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_VOTE   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e r_state, w_next;

  logic                 r_sync1, r_sync2, r_prev;
  logic [TW-1:0]        r_tcnt;
  logic [2:0]           r_bitcnt;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_pbit;
  logic                 r_brk;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid, r_ferr, r_perr, r_ovr;

  logic w_rx, w_tick, w_fall, w_centre, w_vote, w_bit_end, w_maj;
  logic w_restart, w_frame_done, w_xor, w_perr;
  logic w_load, w_accept, w_ovr_evt;

  // Two-flop synchronizer; everything downstream sees only w_rx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_rx = r_sync2;

  uart_baud_tick #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_fall    = r_prev & ~w_rx;
  assign w_centre  = w_tick && (r_tcnt == T_CENTRE);
  assign w_vote    = w_tick && (r_tcnt == T_VOTE);
  assign w_bit_end = w_tick && (r_tcnt == T_LAST);
  assign w_maj     = maj3(r_samp[1], r_samp[0], w_rx);

  assign w_xor  = (^r_data) ^ r_pbit;
  assign w_perr = (PARITY == PARITY_EVEN) ? w_xor :
                  (PARITY == PARITY_ODD)  ? ~w_xor : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_restart    = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_next    = ST_START;
          w_restart = 1'b1;
        end
      end
      ST_START: begin
        // A start bit that is high again at its centre was a glitch.
        if (w_centre && w_rx) begin
          w_next = ST_IDLE;
        end else if (w_bit_end) begin
          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bitcnt == BIT_LAST)) begin
          w_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_brk) begin
          // Low stop bit: stay here until the line is idle again so a
          // break cannot be mistaken for a new start edge.
          if (w_rx) begin
            w_next = ST_IDLE;
          end
        end else if (w_vote) begin
          w_frame_done = 1'b1;
          if (w_maj) begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bit timing and frame assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt   <= '0;
      r_bitcnt <= '0;
      r_samp   <= 2'b11;
      r_data   <= '0;
      r_pbit   <= 1'b0;
      r_brk    <= 1'b0;
    end else begin
      if (w_restart) begin
        r_tcnt   <= '0;
        r_bitcnt <= '0;
      end else begin
        if (w_tick) begin
          r_tcnt <= (r_tcnt == T_LAST) ? '0 : r_tcnt + 1'b1;
        end
        if ((r_state == ST_DATA) && w_bit_end) begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end

      if (w_tick) begin
        r_samp <= {r_samp[0], w_rx};
      end

      if ((r_state == ST_DATA) && w_vote) begin
        r_data <= {w_maj, r_data[DATA_BITS-1:1]};
      end
      if ((r_state == ST_PARITY) && w_vote) begin
        r_pbit <= w_maj;
      end

      if (r_state != ST_STOP) begin
        r_brk <= 1'b0;
      end else if (!r_brk && w_vote && !w_maj) begin
        r_brk <= 1'b1;
      end
    end
  end

  // Holding register. A completing frame loads if the register is empty
  // or is being emptied this very cycle; otherwise it is dropped.
  assign w_accept  = r_valid && data_out_ready;
  assign w_load    = w_frame_done && (!r_valid || data_out_ready);
  assign w_ovr_evt = w_frame_done && r_valid && !data_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout  <= r_data;
        r_ferr  <= ~w_maj;
        r_perr  <= w_perr;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      // A new drop wins over a simultaneous clear.
      if (w_ovr_evt) begin
        r_ovr <= 1'b1;
      end else if (clear_overrun) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign data_out       = r_dout;
  assign data_out_valid = r_valid;
  assign frame_err      = r_ferr;
  assign parity_err     = r_perr;
  assign overrun        = r_ovr;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning payload width, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit, even and >= 8.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-008 SHALL have port serial_in, input, 1, meaning asynchronous RX line, idle high.
REQ-009 SHALL have port data_out, output, DATA_BITS, meaning received payload, LSB first on the line.
REQ-010 SHALL have port data_out_valid, output, 1, meaning holding register full.
REQ-011 SHALL have port data_out_ready, input, 1, meaning consumer accepts.
REQ-012 SHALL have port frame_err, output, 1, meaning the held byte had a low stop bit.
REQ-013 SHALL have port parity_err, output, 1, meaning the held byte failed parity; always 0 when PARITY = 0.
REQ-014 SHALL have port overrun, output, 1, meaning a sticky flag: a frame was dropped.
REQ-015 SHALL have port clear_overrun, input, 1, meaning a single-cycle pulse that clears overrun.

Function
REQ-016 SHALL pass serial_in through a 2-flop synchronizer; all logic uses the synchronized value (2-cycle input latency).
REQ-017 SHALL generate a sample tick every TICK = round(CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE)) cycles; the tick counter restarts on start-edge detection.
REQ-018 SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-020 In START, the line SHALL be evaluated at the bit centre (tick OVERSAMPLE/2); high -> IDLE (glitch rejected, no output); low -> DATA.
REQ-021 Each data, parity and stop bit SHALL be evaluated by a 2-of-3 majority of the samples at centre ticks c-1, c, c+1.
REQ-022 DATA SHALL capture exactly DATA_BITS bits, then -> PARITY if PARITY != 0, else -> STOP.
REQ-023 Parity SHALL be checked as even: XOR(data, parity bit) = 0; odd: XOR = 1.
REQ-024 STOP SHALL evaluate one stop bit (a second stop bit is treated as idle), load the holding register, then -> IDLE.
REQ-025 A low stop bit SHALL set frame_err with the byte (the byte is still delivered), and -> IDLE only after the line returns high (break handling).
REQ-026 data_out_valid SHALL rise 1 cycle after STOP evaluation and stay high until the cycle data_out_valid && data_out_ready.
REQ-027 data_out, frame_err and parity_err SHALL be stable while data_out_valid is high.
REQ-028 If a frame completes while valid && !ready, the new frame SHALL be discarded and overrun set; the held byte is unchanged.
REQ-029 If frame completion coincides with a ready handshake, the new byte SHALL load with no overrun.
REQ-030 If clear_overrun coincides with a new overrun event, overrun SHALL remain set.

Reset
REQ-031 On rst_n low, asynchronously: state=IDLE; counters=0; synchronizer=1; data_out=0; data_out_valid=0; frame_err=0; parity_err=0; overrun=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL start only on a fresh falling edge.

Structure
REQ-033 The state enum and parity-mode constants (NONE/EVEN/ODD) SHALL live in the shared package uart_pkg.
REQ-034 The tick generator SHALL be a sub-module uart_baud_tick, parametrised by CLOCK_FREQ, BAUD_RATE and OVERSAMPLE, with ports clk, rst_n, restart and tick.

Verification
REQ-035 Bench SHALL cover: defaults, ready held 1, send 8'h78 -> data_out_valid once, data_out=8'h78, no error flags.
REQ-036 Bench SHALL cover: PARITY=1, send 8'h35 with a wrong parity bit -> data_out=8'h35, parity_err=1; with the correct bit -> parity_err=0.
REQ-037 Bench SHALL cover: DATA_BITS=7, send 7'h3e -> data_out=7'h3e; the 8th line bit is read as the stop bit.
REQ-038 Bench SHALL cover: ready=0, send 8'h31 then 8'h0d -> data_out stays 8'h31, overrun=1; clear_overrun pulse -> overrun=0.
REQ-039 Bench SHALL cover: a 3-cycle low glitch on an idle line -> no data_out_valid; a stop bit forced low on 8'h0a -> frame_err=1, no new frame until the line is high.
REQ-040 Bench SHALL cover: rst_n pulsed low mid-byte of 8'h79, then a full 8'h7a sent -> only 8'h7a is received.
